// File: rtl/baud_detect_if.sv
// Signal bundle for the autobaud detector: arm/rx toward the detector and
// rate/status back.
interface baud_detect_if;
    logic       arm;
    logic       rx;
    logic [1:0] bd_rate;
    logic       locked;
    logic       busy;
    logic       err;

    modport master (output arm, rx, input bd_rate, locked, busy, err);
    modport slave  (input arm, rx, output bd_rate, locked, busy, err);
endinterface

// File: rtl/baud_detect.sv
// Autobaud detector. It measures the first two low bits of a 0x55 sync
// character on rx and reports the matching standard rate (1200..9600 baud).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | not armed, rx ignored
// WAIT_HIGH  | armed, waiting for the line to be idle high
// WAIT_FALL1 | waiting for the falling edge of the start bit
// MEAS1      | counting the low width of the first bit pair
// GAP        | counting the high width between the two low bits
// MEAS2      | counting the low width of the second bit, compared to MEAS1
// DONE       | rate locked, holds until the next arm
module baud_detect #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic          clk,
    input  logic          reset_n,
    baud_detect_if.slave  bd
);
    localparam int P9600 = CLK_FREQ / 9600;
    localparam int P4800 = CLK_FREQ / 4800;
    localparam int P2400 = CLK_FREQ / 2400;
    localparam int P1200 = CLK_FREQ / 1200;
    localparam int T_MIN = P9600 * 3 / 4;
    localparam int T3    = P9600 * 3 / 2;
    localparam int T2    = P4800 * 3 / 2;
    localparam int T1    = P2400 * 3 / 2;
    localparam int T0    = P1200 * 3 / 2;
    localparam int CW    = $clog2(T0 + 1);

    localparam logic [CW-1:0] TMIN_C  = CW'(T_MIN);
    localparam logic [CW-1:0] T3_C    = CW'(T3);
    localparam logic [CW-1:0] T2_C    = CW'(T2);
    localparam logic [CW-1:0] T1_C    = CW'(T1);
    localparam logic [CW-1:0] T0_M1_C = CW'(T0 - 1);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WAIT_HIGH  = 3'd1;
    localparam logic [2:0] WAIT_FALL1 = 3'd2;
    localparam logic [2:0] MEAS1      = 3'd3;
    localparam logic [2:0] GAP        = 3'd4;
    localparam logic [2:0] MEAS2      = 3'd5;
    localparam logic [2:0] DONE       = 3'd6;

    logic          rx_meta, rx_s;
    logic [2:0]    state;
    logic [CW-1:0] count;
    logic [1:0]    c1;
    logic [1:0]    bd_rate_q;
    logic          locked_q, err_q;
    logic          cls_ok;
    logic [1:0]    cls_code;
    logic          at_limit;

    // Returns {valid, rate code}; widths at or beyond T0 never reach here
    // because the counting states abort first.
    function automatic logic [2:0] classify(input logic [CW-1:0] n);
        if (n < TMIN_C)    return 3'b000;
        else if (n < T3_C) return {1'b1, 2'd3};
        else if (n < T2_C) return {1'b1, 2'd2};
        else if (n < T1_C) return {1'b1, 2'd1};
        else               return {1'b1, 2'd0};
    endfunction

    assign {cls_ok, cls_code} = classify(count);
    assign at_limit           = (count == T0_M1_C);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bd.rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            count     <= '0;
            c1        <= 2'd0;
            bd_rate_q <= 2'd0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (bd.arm) begin
                // arm overrides any error or lock decided in the same cycle
                state    <= WAIT_HIGH;
                count    <= '0;
                locked_q <= 1'b0;
            end else begin
                case (state)
                    WAIT_HIGH: begin
                        if (rx_s) state <= WAIT_FALL1;
                    end
                    WAIT_FALL1: begin
                        if (!rx_s) begin
                            state <= MEAS1;
                            count <= ONE_C;
                        end
                    end
                    MEAS1: begin
                        if (!rx_s) begin
                            if (at_limit) begin
                                state <= WAIT_HIGH;
                                count <= '0;
                                err_q <= 1'b1;
                            end else begin
                                count <= count + ONE_C;
                            end
                        end else if (!cls_ok) begin
                            state <= WAIT_HIGH;
                            count <= '0;
                            err_q <= 1'b1;
                        end else begin
                            c1    <= cls_code;
                            state <= GAP;
                            count <= ONE_C;
                        end
                    end
                    GAP: begin
                        if (!rx_s) begin
                            state <= MEAS2;
                            count <= ONE_C;
                        end else if (at_limit) begin
                            state <= WAIT_HIGH;
                            count <= '0;
                            err_q <= 1'b1;
                        end else begin
                            count <= count + ONE_C;
                        end
                    end
                    MEAS2: begin
                        if (!rx_s) begin
                            if (at_limit) begin
                                state <= WAIT_HIGH;
                                count <= '0;
                                err_q <= 1'b1;
                            end else begin
                                count <= count + ONE_C;
                            end
                        end else if (cls_ok && (cls_code == c1)) begin
                            state     <= DONE;
                            count     <= '0;
                            bd_rate_q <= c1;
                            locked_q  <= 1'b1;
                        end else begin
                            state <= WAIT_HIGH;
                            count <= '0;
                            err_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bd.bd_rate = bd_rate_q;
    assign bd.locked  = locked_q;
    assign bd.err     = err_q;
    assign bd.busy    = (state != IDLE) && (state != DONE);
endmodule

// File: tb/tb_baud_detect.sv
// Scoreboard bench for baud_detect at CLK_FREQ=96000 (T_MIN=7, T3=15, T2=30,
// T1=60, T0=120); lock and err events are matched against a queue.
module tb_baud_detect;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    baud_detect_if bif ();

    baud_detect #(.CLK_FREQ(96000)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bd      (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_lock;
        logic [1:0] rate;
        logic       busy;
    } exp_t;

    exp_t       q[$];
    int         n_vec  = 0;
    int         n_miss = 0;
    logic [1:0] exp_rate = 2'd0;
    logic       prev_locked = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        bif.arm = 1'b1;
        tick();
        bif.arm = 1'b0;
    endtask

    task automatic expect_lock(input logic [1:0] r);
        q.push_back('{1'b1, r, 1'b0});
        exp_rate = r;
    endtask

    task automatic expect_err();
        q.push_back('{1'b0, exp_rate, 1'b1});
    endtask

    task automatic line(input int lo1, input int hi, input int lo2);
        bif.rx = 1'b0;
        repeat (lo1) tick();
        bif.rx = 1'b1;
        repeat (hi) tick();
        bif.rx = 1'b0;
        repeat (lo2) tick();
        bif.rx = 1'b1;
        repeat (12) tick();
    endtask

    // Monitor: every err pulse or locked rising edge is one DUT event.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bif.err || (bif.locked && !prev_locked)) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_event: got err=%0b locked=%0b rate=%0d, expected no event",
                             bif.err, bif.locked, bif.bd_rate);
                end else begin
                    e = q.pop_front();
                    check("event_is_lock", {31'd0, bif.locked && !prev_locked && !bif.err}, {31'd0, e.is_lock});
                    check("event_rate", {30'd0, bif.bd_rate}, {30'd0, e.rate});
                    check("event_busy", {31'd0, bif.busy}, {31'd0, e.busy});
                end
            end
            prev_locked = bif.locked;
        end
    end

    initial begin
        bif.arm = 1'b0;
        bif.rx  = 1'b1;
        #23;
        check("rst_bd_rate", {30'd0, bif.bd_rate}, 32'd0);
        check("rst_locked", {31'd0, bif.locked}, 32'd0);
        check("rst_err", {31'd0, bif.err}, 32'd0);
        check("rst_busy", {31'd0, bif.busy}, 32'd0);
        reset_n = 1'b1;
        repeat (3) tick();
        check("idle_busy", {31'd0, bif.busy}, 32'd0);

        // 20-cycle bits -> 4800
        pulse_arm();
        check("armed_busy", {31'd0, bif.busy}, 32'd1);
        expect_lock(2'd2);
        line(20, 20, 20);
        check("done_busy", {31'd0, bif.busy}, 32'd0);

        // rx activity in DONE is ignored
        line(10, 10, 10);
        check("done_hold_locked", {31'd0, bif.locked}, 32'd1);
        check("done_hold_rate", {30'd0, bif.bd_rate}, 32'd2);

        pulse_arm();
        expect_lock(2'd3);
        line(10, 10, 10);
        pulse_arm();
        expect_lock(2'd0);
        line(80, 80, 80);

        // glitch, then auto-retry with 40-cycle bits
        pulse_arm();
        expect_err();
        bif.rx = 1'b0;
        repeat (5) tick();
        bif.rx = 1'b1;
        repeat (10) tick();
        check("retry_busy", {31'd0, bif.busy}, 32'd1);
        expect_lock(2'd1);
        line(40, 40, 40);

        // class mismatch, then line stuck low past T0
        pulse_arm();
        expect_err();
        line(20, 20, 40);
        expect_err();
        bif.rx = 1'b0;
        repeat (130) tick();
        bif.rx = 1'b1;
        repeat (10) tick();
        check("stuck_locked", {31'd0, bif.locked}, 32'd0);

        // boundaries
        pulse_arm();
        expect_lock(2'd3);
        line(14, 14, 14);
        pulse_arm();
        expect_lock(2'd2);
        line(15, 15, 15);
        pulse_arm();
        expect_lock(2'd0);
        line(119, 119, 119);

        // arm in the same cycle the lock would be taken
        pulse_arm();
        bif.rx = 1'b0;
        repeat (20) tick();
        bif.rx = 1'b1;
        repeat (20) tick();
        bif.rx = 1'b0;
        repeat (20) tick();
        bif.rx = 1'b1;
        tick();
        tick();
        pulse_arm();
        repeat (12) tick();
        check("armwin_locked", {31'd0, bif.locked}, 32'd0);
        check("armwin_busy", {31'd0, bif.busy}, 32'd1);
        expect_lock(2'd2);
        line(20, 20, 20);

        // re-arm from DONE, then reset in the middle of MEAS1
        pulse_arm();
        @(negedge clk);
        check("rearm_locked", {31'd0, bif.locked}, 32'd0);
        check("rearm_rate", {30'd0, bif.bd_rate}, 32'd2);
        check("rearm_busy", {31'd0, bif.busy}, 32'd1);
        repeat (4) tick();
        bif.rx = 1'b0;
        repeat (10) tick();
        #5;
        reset_n = 1'b0;
        #1;
        check("midrst_bd_rate", {30'd0, bif.bd_rate}, 32'd0);
        check("midrst_locked", {31'd0, bif.locked}, 32'd0);
        check("midrst_err", {31'd0, bif.err}, 32'd0);
        check("midrst_busy", {31'd0, bif.busy}, 32'd0);
        exp_rate = 2'd0;
        repeat (3) tick();
        reset_n = 1'b1;
        bif.rx = 1'b1;
        repeat (5) tick();
        line(20, 20, 20);
        check("post_rst_busy", {31'd0, bif.busy}, 32'd0);
        check("post_rst_locked", {31'd0, bif.locked}, 32'd0);

        repeat (20) tick();
        check("pending_events", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/baud_detect.md
BAUD_DETECT -- requirements
Module: baud_detect

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Derived constants: Pb = CLK_FREQ/b for b in {1200,2400,4800,9600}; T_MIN = P9600*3/4; T3 = P9600*3/2; T2 = P4800*3/2; T1 = P2400*3/2; T0 = P1200*3/2; all integer-truncated.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 arm  input  1  single-cycle pulse; starts or restarts detection.
REQ-006 rx  input  1  asynchronous serial line, idle high; carries sync char 0x55, 8N1, LSB first.
REQ-007 bd_rate  output  2  detected rate code, same encoding as baud_gen bd_rate: 0=1200, 1=2400, 2=4800, 3=9600.
REQ-008 locked  output  1  level; bd_rate valid from a completed detection.
REQ-009 busy  output  1  level; high in any state other than IDLE and DONE.
REQ-010 err  output  1  single-cycle pulse on a failed measurement.

Function
REQ-011 rx passes through a 2-flop synchronizer; all logic uses the synchronized signal rx_s only.
REQ-012 Internal counter width = $clog2(T0+1); it never wraps: every state that counts aborts when count reaches T0.
REQ-013 FSM states: IDLE, WAIT_HIGH, WAIT_FALL1, MEAS1, GAP, MEAS2, DONE.
REQ-014 IDLE: waits for arm; arm -> WAIT_HIGH.
REQ-015 WAIT_HIGH: rx_s=1 for one cycle -> WAIT_FALL1 (rejects a line already low when armed); no timeout.
REQ-016 WAIT_FALL1: rx_s=0 -> MEAS1 with count=1; no timeout.
REQ-017 MEAS1: count increments each cycle with rx_s=0; on rx_s=1, the count N1 is classified and the FSM goes to GAP with count=1.
REQ-018 Classification of N: N<T_MIN -> error; T_MIN<=N<T3 -> 3; T3<=N<T2 -> 2; T2<=N<T1 -> 1; T1<=N<T0 -> 0; count reaching T0 -> error immediately.
REQ-019 GAP: counts rx_s=1 cycles; rx_s=0 -> MEAS2 with count=1; count reaching T0 -> error.
REQ-020 MEAS2: same as MEAS1, producing class C2; on rx_s=1, if C2 equals class C1 of N1 -> DONE, else error.
REQ-021 On entry to DONE: bd_rate<=C1 and locked<=1, both visible in the cycle after the rising rx_s edge that ends MEAS2.
REQ-022 Error in any state: err=1 for exactly one cycle, FSM -> WAIT_HIGH (auto-retry), locked stays 0, bd_rate unchanged.
REQ-023 DONE: holds until arm; arm -> WAIT_HIGH, locked<=0 in the next cycle, bd_rate keeps its last value.
REQ-024 arm in any busy state restarts at WAIT_HIGH with count cleared; no err pulse.
REQ-025 arm in the same cycle as an error or lock condition: arm wins; no err pulse, locked stays 0.
REQ-026 rx activity in IDLE or DONE is ignored.

Reset
REQ-027 Asynchronous assertion of reset_n=0: FSM=IDLE, count=0, synchronizer flops=1, bd_rate=0, locked=0, err=0, busy=0.
REQ-028 Reset mid-measurement abandons the measurement with no err pulse; after release, detection requires a new arm.

Verification (CLK_FREQ=96000: P9600=10, T_MIN=7, T3=15, T2=30, T1=60, T0=120)
REQ-029 arm; rx low 20 cycles, high 20, low 20, high -> locked=1, bd_rate=2, no err.
REQ-030 arm; low 10, high 10, low 10, high -> bd_rate=3, locked=1. Repeat with 80-cycle bits -> bd_rate=0.
REQ-031 arm; low 5 cycles (glitch) -> err pulse of 1 cycle, busy stays 1; then valid 40-cycle pattern -> bd_rate=1, locked=1.
REQ-032 arm; low 20, high 20, low 40 -> err pulse (class mismatch); rx held low 130 cycles -> err pulse when count reaches 120.
REQ-033 Locked at bd_rate=2; arm -> locked=0 next cycle, bd_rate still 2; reset_n=0 asserted mid-MEAS1 -> all outputs at reset values immediately, no err.
REQ-034 Class boundaries: a valid two-pulse pattern with N=14 -> bd_rate=3; with N=15 -> bd_rate=2; with N=119 -> bd_rate=0.
